vram_write_arbiter: RTL and testbench
=====================================

# vram_write_arbiter

Shares the single write port of the display VRAM and game-state RAM between the simulation engine (game state controller) and a user brush painter that injects sand cells. Simulation writes go straight to arbitration; brush writes pass through a small FIFO. Brush traffic takes priority during vertical blanking, and a starvation counter guarantees it progress during active video. The registered write port drives `write_en`, `write_address_i` and `write_data_i` of both RAMs.

## Interface
- `ADDR_WIDTH`, default 19: RAM address width (clog2 of 640*480).
- `DATA_WIDTH`, default 1: cell data width.
- `PIXELS`, default 307200: number of valid cells. Brush addresses at or above this value are illegal.
- `FIFO_DEPTH`, default 4: brush FIFO entries. Power of two, at least 2.
- `STARVE_LIMIT`, default 8: number of consecutive lost slots after which the brush is forced a grant. Range 1..255.

Ports:
- `clk_i`  in  1  single clock; all logic is on its rising edge.
- `reset_i`  in  1  synchronous reset, active-low.
- `vblank_i`  in  1  high during vertical blanking.
- `sim_valid_i`  in  1  simulation write request.
- `sim_ready_o`  out  1  simulation write accepted this cycle.
- `sim_addr_i`  in  ADDR_WIDTH  simulation write address.
- `sim_data_i`  in  DATA_WIDTH  simulation write data.
- `brush_valid_i`  in  1  brush write request.
- `brush_ready_o`  out  1  brush FIFO can accept.
- `brush_addr_i`  in  ADDR_WIDTH  brush write address.
- `brush_data_i`  in  DATA_WIDTH  brush write data.
- `wr_en_o`  out  1  registered RAM write enable.
- `wr_addr_o`  out  ADDR_WIDTH  registered RAM write address.
- `wr_data_o`  out  DATA_WIDTH  registered RAM write data.
- `fifo_count_o`  out  clog2(FIFO_DEPTH)+1  current brush FIFO occupancy.
- `addr_err_o`  out  1  sticky flag: an illegal brush address was dropped.

## Operation
- **Brush intake**
  - `brush_ready_o` = FIFO not full. It does not account for a same-cycle pop.
  - A handshake is `brush_valid_i & brush_ready_o`.
  - On a handshake with `brush_addr_i < PIXELS`: push the entry.
  - On a handshake with `brush_addr_i >= PIXELS`: discard the entry (nothing is pushed) and set `addr_err_o`.
- **Arbitration** is evaluated every cycle, with `ne` = FIFO not empty:
  - `force` = `ne & (vblank_i | starve == STARVE_LIMIT)`.
  - `sim_ready_o` = `~force`. It does not depend on `sim_valid_i`.
  - `sim_take` = `sim_valid_i & sim_ready_o`.
  - `pop` = `ne & (force | ~sim_valid_i)`.
  - `sim_take` and `pop` are mutually exclusive.
- **Starvation counter** `starve`, 8 bits:
  - Cleared on `pop` or when the FIFO is empty.
  - Otherwise incremented on `sim_take` while `ne`, saturating at `STARVE_LIMIT`.
- **Output register**, updated every cycle:
  - `wr_en_o` ← `sim_take | pop`.
  - `wr_addr_o`/`wr_data_o` ← the sim inputs on `sim_take`, the FIFO head on `pop`, otherwise hold the previous value.
- **FIFO**: simultaneous push and pop is allowed at any occupancy except full, where the push is refused because ready is low. A push into an empty FIFO is not bypassed.

## Timing
- **Reset** (`reset_i` low at a clock edge):
  - Registered state: `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `fifo_count_o`=0, `addr_err_o`=0, `starve`=0, FIFO pointers at 0.
  - While `reset_i` is low, `sim_ready_o` and `brush_ready_o` are forced to 0.
  - Reset mid-operation discards all queued brush entries and any pending output; no partial write is emitted afterwards.
- **Latency**
  - Sim handshake at cycle N gives `wr_en_o` at N+1.
  - Brush handshake at N: earliest `wr_en_o` is N+2 (push N, head valid N+1, pop N+1).
- **Occupancy**: `fifo_count_o` updates one cycle after a push or pop. It is unchanged on a simultaneous push and pop.
- **Throughput**: at most one write per cycle.
- **Starvation bound**: outside vblank, with `sim_valid_i` held high and the FIFO non-empty, the brush gets one grant after every `STARVE_LIMIT` sim grants.
- **Vblank**: while `vblank_i` is high and the FIFO is non-empty, `sim_ready_o`=0. The FIFO drains at one entry per cycle.
- **Pointer wrap**: pointers wrap modulo `FIFO_DEPTH`. Full/empty is resolved with an extra pointer bit.

## Test plan
- **Reset**: hold `reset_i`=0 for 3 cycles with all valids high -> both readys 0, `wr_en_o`=0, `fifo_count_o`=0.
- **Sim only**: `sim_valid_i`=1 with addr 0x00010/data 1, brush idle -> `sim_ready_o`=1, `wr_en_o`=1 with addr 0x00010/data 1 exactly one cycle later.
- **Starvation**: sim valid continuously, `vblank_i`=0, one brush write to 0x12C00 -> 8 sim writes, then the brush write appears on `wr_*_o`, then sim writes resume.
- **Vblank drain and backpressure**: 5 back-to-back brush writes with depth 4 -> the 5th waits while `brush_ready_o`=0. Raise `vblank_i` -> `sim_ready_o`=0, all 5 brush writes are emitted in order, then `sim_ready_o` returns to 1.
- **Illegal address**: brush addr 307200 -> no write emitted, `fifo_count_o` stays 0, `addr_err_o`=1 and stays 1 until reset.
- **Reset mid-operation**: FIFO holding 3 entries, pulse `reset_i` low for 1 cycle -> `fifo_count_o`=0, and no stale brush write ever appears on `wr_en_o`.

Source files
------------

// File: rtl/vram_write_arbiter_if.sv
// rtl/vram_write_arbiter_if.sv - sim/brush request channels and the registered RAM write port
interface vram_write_arbiter_if #(
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 1
);
   logic                  sim_valid_i;
   logic                  sim_ready_o;
   logic [ADDR_WIDTH-1:0] sim_addr_i;
   logic [DATA_WIDTH-1:0] sim_data_i;
   logic                  brush_valid_i;
   logic                  brush_ready_o;
   logic [ADDR_WIDTH-1:0] brush_addr_i;
   logic [DATA_WIDTH-1:0] brush_data_i;
   logic                  wr_en_o;
   logic [ADDR_WIDTH-1:0] wr_addr_o;
   logic [DATA_WIDTH-1:0] wr_data_o;

   modport master (
      output sim_valid_i, sim_addr_i, sim_data_i,
      output brush_valid_i, brush_addr_i, brush_data_i,
      input  sim_ready_o, brush_ready_o,
      input  wr_en_o, wr_addr_o, wr_data_o
   );

   modport slave (
      input  sim_valid_i, sim_addr_i, sim_data_i,
      input  brush_valid_i, brush_addr_i, brush_data_i,
      output sim_ready_o, brush_ready_o,
      output wr_en_o, wr_addr_o, wr_data_o
   );
endinterface

// File: rtl/vram_write_arbiter.sv
// rtl/vram_write_arbiter.sv - shares the VRAM write port between simulation and a FIFO-buffered brush
module vram_write_arbiter #(
   parameter int ADDR_WIDTH   = 19,
   parameter int DATA_WIDTH   = 1,
   parameter int PIXELS       = 307200,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          vblank_i,
   vram_write_arbiter_if.slave           bus,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic                          addr_err_o
);
   localparam int          PW       = $clog2(FIFO_DEPTH);
   localparam logic [7:0]  SL       = 8'(STARVE_LIMIT);
   localparam logic [31:0] PIX      = 32'(PIXELS);

   logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic [PW:0]           wr_ptr, rd_ptr;
   logic [7:0]            starve;

   logic empty, full, ne, force_brush, sim_take, pop, brush_hs, push, addr_ok;

   // Extra pointer bit distinguishes full from empty when the index bits match.
   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign ne          = ~empty;
   assign force_brush = ne & (vblank_i | (starve == SL));

   assign bus.sim_ready_o   = reset_i & ~force_brush;
   assign bus.brush_ready_o = reset_i & ~full;

   assign sim_take = bus.sim_valid_i & bus.sim_ready_o;
   assign pop      = reset_i & ne & (force_brush | ~bus.sim_valid_i);
   assign brush_hs = bus.brush_valid_i & bus.brush_ready_o;
   assign addr_ok  = (32'(bus.brush_addr_i) < PIX);
   assign push     = brush_hs & addr_ok;

   assign fifo_count_o = wr_ptr - rd_ptr;

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_addr[wr_ptr[PW-1:0]] <= bus.brush_addr_i;
         mem_data[wr_ptr[PW-1:0]] <= bus.brush_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         starve        <= '0;
         bus.wr_en_o   <= 1'b0;
         bus.wr_addr_o <= '0;
         bus.wr_data_o <= '0;
         addr_err_o    <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;

         // Counts sim wins while brush work is waiting; any brush grant resets it.
         if (pop || empty)
            starve <= '0;
         else if (sim_take && starve != SL)
            starve <= starve + 8'd1;

         bus.wr_en_o <= sim_take | pop;
         if (sim_take) begin
            bus.wr_addr_o <= bus.sim_addr_i;
            bus.wr_data_o <= bus.sim_data_i;
         end else if (pop) begin
            bus.wr_addr_o <= mem_addr[rd_ptr[PW-1:0]];
            bus.wr_data_o <= mem_data[rd_ptr[PW-1:0]];
         end

         if (brush_hs && !addr_ok)
            addr_err_o <= 1'b1;
      end
   end
endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb/tb_vram_write_arbiter.sv - randomized and directed checks against a queue-based reference model
module tb_vram_write_arbiter;
   localparam int AW = 19, DW = 1, PIXELS = 307200, DEPTH = 4, SL = 8;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   logic clk = 1'b0, rst_n = 1'b0, vblank = 1'b0;
   logic [$clog2(DEPTH):0] fifo_count;
   logic addr_err;
   int total = 0, bad = 0;

   ent_t          q[$];
   int            m_starve = 0;
   logic          m_wen = 0, m_err = 0;
   logic [AW-1:0] m_waddr = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [AW-1:0] obs[$];
   bit            hs_seen;

   vram_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   vram_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIXELS(PIXELS),
                        .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(SL)) dut (
      .clk_i(clk), .reset_i(rst_n), .vblank_i(vblank), .bus(bus),
      .fifo_count_o(fifo_count), .addr_err_o(addr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: check ready outputs, advance the model at the edge, then check registered outputs.
   task automatic cycle();
      bit ne, fb, esr, ebr, take, pop;
      ent_t e;
      #1;
      ne  = q.size() > 0;
      fb  = ne && (vblank || m_starve == SL);
      esr = rst_n && !fb;
      ebr = rst_n && q.size() < DEPTH;
      chk("sim_ready", bus.sim_ready_o, esr);
      chk("brush_ready", bus.brush_ready_o, ebr);
      hs_seen = bus.brush_valid_i && ebr;
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         m_starve = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_err = 0;
      end else begin
         take  = bus.sim_valid_i && esr;
         pop   = ne && (fb || !bus.sim_valid_i);
         m_wen = take || pop;
         if (take) begin
            m_waddr = bus.sim_addr_i; m_wdata = bus.sim_data_i;
         end else if (pop) begin
            e = q.pop_front();
            m_waddr = e.a; m_wdata = e.d;
         end
         if (pop || !ne) m_starve = 0;
         else if (take && m_starve < SL) m_starve++;
         if (bus.brush_valid_i && ebr) begin
            if (int'(bus.brush_addr_i) < PIXELS) begin
               e.a = bus.brush_addr_i; e.d = bus.brush_data_i;
               q.push_back(e);
            end else m_err = 1;
         end
      end
      #1;
      chk("wr_en", bus.wr_en_o, m_wen);
      chk("wr_addr", bus.wr_addr_o, m_waddr);
      chk("wr_data", bus.wr_data_o, m_wdata);
      chk("fifo_count", fifo_count, q.size());
      chk("addr_err", addr_err, m_err);
      if (bus.wr_en_o) obs.push_back(bus.wr_addr_o);
   endtask

   task automatic idle_inputs();
      bus.sim_valid_i = 0; bus.sim_addr_i = '0; bus.sim_data_i = '0;
      bus.brush_valid_i = 0; bus.brush_addr_i = '0; bus.brush_data_i = '0;
      vblank = 0;
   endtask

   task automatic do_reset(input int n);
      rst_n = 0;
      for (int i = 0; i < n; i++) cycle();
      rst_n = 1;
   endtask

   initial begin
      int idx, budget, wcount;
      idle_inputs();
      // Reset with every request asserted.
      bus.sim_valid_i = 1; bus.brush_valid_i = 1; bus.brush_addr_i = 19'd5;
      do_reset(3);
      chk("rst_sim_ready", bus.sim_ready_o, 0);
      chk("rst_brush_ready", bus.brush_ready_o, 0);
      chk("rst_wr_en", bus.wr_en_o, 0);
      chk("rst_count", fifo_count, 0);
      idle_inputs();
      cycle();

      // Sim only: single write appears one cycle later.
      bus.sim_valid_i = 1; bus.sim_addr_i = 19'h00010; bus.sim_data_i = 1'b1;
      cycle();
      chk("simonly_wen", bus.wr_en_o, 1);
      chk("simonly_addr", bus.wr_addr_o, 19'h00010);
      chk("simonly_data", bus.wr_data_o, 1);
      bus.sim_valid_i = 0;
      cycle();

      // Starvation: brush entry waits for exactly SL sim grants.
      bus.sim_valid_i = 1;
      bus.brush_valid_i = 1; bus.brush_addr_i = 19'h12C00; bus.brush_data_i = 1;
      bus.sim_addr_i = 19'($urandom_range(16'hFFFF, 16'h1000));
      cycle();
      bus.brush_valid_i = 0;
      obs.delete();
      for (int i = 0; i < 14; i++) begin
         bus.sim_addr_i = 19'($urandom_range(16'hFFFF, 16'h1000));
         bus.sim_data_i = 1'($urandom);
         cycle();
      end
      idx = -1;
      foreach (obs[i]) if (obs[i] == 19'h12C00 && idx < 0) idx = i;
      chk("starve_pos", idx, SL);
      chk("starve_after", obs.size(), 14);

      // Vblank drain with backpressure on the fifth brush write.
      idle_inputs();
      do_reset(1);
      bus.sim_valid_i = 1; bus.sim_addr_i = 19'h2000;
      for (int k = 0; k < 4; k++) begin
         bus.brush_valid_i = 1; bus.brush_addr_i = 19'(100 + k); bus.brush_data_i = 1'(k);
         budget = 0;
         do begin cycle(); budget++; end while (!hs_seen && budget < 20);
         chk("vb_push_timeout", hs_seen, 1);
      end
      bus.brush_addr_i = 19'd104; bus.brush_data_i = 0;
      cycle(); cycle();
      chk("vb_backpressure", bus.brush_ready_o, 0);
      obs.delete();
      vblank = 1;
      budget = 0;
      do begin cycle(); budget++; end while (!hs_seen && budget < 20);
      chk("vb_fifth_timeout", hs_seen, 1);
      bus.brush_valid_i = 0;
      budget = 0;
      while (fifo_count != 0 && budget < 20) begin cycle(); budget++; end
      cycle();
      chk("vb_sim_ready_back", bus.sim_ready_o, 1);
      wcount = 0;
      foreach (obs[i]) if (obs[i] >= 100 && obs[i] <= 104) begin
         chk("vb_order", obs[i], 100 + wcount);
         wcount++;
      end
      chk("vb_drained", wcount, 5);

      // Illegal brush address is dropped and the error sticks.
      idle_inputs();
      do_reset(1);
      bus.brush_valid_i = 1; bus.brush_addr_i = 19'(PIXELS);
      cycle();
      bus.brush_valid_i = 0;
      obs.delete();
      for (int i = 0; i < 5; i++) cycle();
      chk("illegal_count", fifo_count, 0);
      chk("illegal_err", addr_err, 1);
      chk("illegal_nowrite", obs.size(), 0);

      // Reset with three queued entries discards them.
      bus.sim_valid_i = 1; bus.sim_addr_i = 19'h3000;
      for (int k = 0; k < 3; k++) begin
         bus.brush_valid_i = 1; bus.brush_addr_i = 19'(200 + k);
         cycle();
      end
      bus.brush_valid_i = 0; bus.sim_valid_i = 0;
      chk("mid_count_pre", fifo_count, 3);
      do_reset(1);
      chk("mid_count", fifo_count, 0);
      obs.delete();
      for (int i = 0; i < 6; i++) cycle();
      chk("mid_no_stale", obs.size(), 0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         rst_n  = ($urandom_range(99) != 0);
         vblank = ($urandom_range(7) == 0);
         bus.sim_valid_i   = 1'($urandom);
         bus.sim_addr_i    = 19'($urandom);
         bus.sim_data_i    = 1'($urandom);
         bus.brush_valid_i = 1'($urandom);
         bus.brush_addr_i  = ($urandom_range(9) == 0) ? 19'($urandom_range(19'h7FFFF, PIXELS))
                                                      : 19'($urandom_range(PIXELS - 1));
         bus.brush_data_i  = 1'($urandom);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
